logic_unit_pipe: RTL and testbench

//  Parametrised, pipelined bitwise logic unit: successor to the fixed 16-bit OR slice.

---
 rtl/logic_unit_pipe.sv | 87 ++++++++
 tb/tb_logic_unit_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready bitwise logic unit with accumulator and result flags
module logic_unit_pipe #(
   parameter  int WIDTH = 16,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             use_acc,
   input  logic             acc_wr,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             parity,
   output logic [CW-1:0]    ones
);
   logic             r_s1_valid, r_s2_valid, r_zero, r_parity;
   logic [WIDTH-1:0] r_s1, r_res, r_acc, w_a_eff, w_op;
   logic [CW-1:0]    r_ones, w_ones;
   logic             w_s2_adv, w_accept;
   assign w_s2_adv = !r_s2_valid || out_ready;
   assign in_ready = !r_s1_valid || w_s2_adv;
   assign w_accept = in_valid && in_ready;
   assign w_a_eff  = use_acc ? r_acc : a;
   // operand mux result for the eight bitwise ops
   always_comb begin
      w_op = op == 3'b000 ? (w_a_eff & b)    :
             op == 3'b001 ? (w_a_eff | b)    :
             op == 3'b010 ? (w_a_eff ^ b)    :
             op == 3'b011 ? ~(w_a_eff & b)   :
             op == 3'b100 ? ~(w_a_eff | b)   :
             op == 3'b101 ? ~(w_a_eff ^ b)   :
             op == 3'b110 ? ~w_a_eff         : b;
   end
   // popcount of the stage-1 value, registered into stage 2 with the result
   always_comb begin
      w_ones = '0;
      for (int i = 0; i < WIDTH; i++) w_ones = w_ones + CW'(r_s1[i]);
   end
   // stage 1: capture op result on accept, drain when stage 2 takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
      end else if (w_accept) begin
         r_s1_valid <= 1'b1;
         r_s1       <= w_op;
      end else if (w_s2_adv) begin
         r_s1_valid <= 1'b0;
      end
   end
   // stage 2: result and flags; data only reloads when stage 1 holds a transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_res      <= '0;
         r_zero     <= 1'b0;
         r_parity   <= 1'b0;
         r_ones     <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_res    <= r_s1;
            r_zero   <= r_s1 == '0;
            r_parity <= ^r_s1;
            r_ones   <= w_ones;
         end
      end
   end
   // accumulator: clear wins over a write of the accepted result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_acc <= '0;
      else if (acc_clr) r_acc <= '0;
      else if (w_accept && acc_wr) r_acc <= w_op;
   end
   assign out_valid = r_s2_valid;
   assign result    = r_res;
   assign zero      = r_zero;
   assign parity    = r_parity;
   assign ones      = r_ones;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: vector table, directed corner sequences and random scoreboard check
module tb_logic_unit_pipe;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready, use_acc = 1'b0, acc_wr = 1'b0, acc_clr = 1'b0;
   logic        out_valid, out_ready = 1'b1, zero, parity;
   logic [2:0]  op = '0;
   logic [15:0] a = '0, b = '0, result;
   logic [4:0]  ones;
   int          n_cmp = 0, n_err = 0;
   typedef struct {
      logic [2:0]  op;
      logic [15:0] a, b, res;
      int          ones;
   } vec_t;
   vec_t        vt[8];
   logic [15:0] q[$];
   logic [15:0] acc_m, ea, exp_r, prev_res;
   logic        prev_stall;
   logic        fire;
   logic        ofire;
   logic_unit_pipe #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
      .use_acc(use_acc), .acc_wr(acc_wr), .acc_clr(acc_clr), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .parity(parity), .ones(ones)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [2:0] o, input logic [15:0] aa, input logic [15:0] bb,
                        input logic ua, input logic aw, input logic ac);
      in_valid = v; op = o; a = aa; b = bb; use_acc = ua; acc_wr = aw; acc_clr = ac;
   endtask
   task automatic chk_out(input string name, input logic [15:0] r);
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_res"}, 32'(result), 32'(r));
      chk({name, "_flags"}, {25'd0, ones, parity, zero}, {25'd0, 5'($countones(r)), ^r, r == 16'd0});
   endtask
   function automatic logic [15:0] ref_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
      case (o)
         3'd0: return x & y;
         3'd1: return x | y;
         3'd2: return x ^ y;
         3'd3: return ~(x & y);
         3'd4: return ~(x | y);
         3'd5: return ~(x ^ y);
         3'd6: return ~x;
         default: return y;
      endcase
   endfunction
   initial begin
      vt[0] = '{3'd1, 16'h0475, 16'h5976, 16'h5D77, 11};
      vt[1] = '{3'd2, 16'h0475, 16'h5976, 16'h5D03, 7};
      vt[2] = '{3'd0, 16'h0475, 16'h5976, 16'h0074, 4};
      vt[3] = '{3'd3, 16'hFFFF, 16'hFFFF, 16'h0000, 0};
      vt[4] = '{3'd6, 16'h0000, 16'h1234, 16'hFFFF, 16};
      vt[5] = '{3'd4, 16'h0475, 16'h5976, 16'hA288, 5};
      vt[6] = '{3'd5, 16'h0475, 16'h5976, 16'hA2FC, 9};
      vt[7] = '{3'd7, 16'hFFFF, 16'h1234, 16'h1234, 5};
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", {result, 11'd0, ones}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      // vector table: one transaction at a time, latency checked at the intermediate negedge
      foreach (vt[i]) begin
         @(negedge clk);
         drive(1'b1, vt[i].op, vt[i].a, vt[i].b, 1'b0, 1'b0, 1'b0);
         @(negedge clk);
         in_valid = 1'b0;
         chk($sformatf("vec%0d_lat", i), 32'(out_valid), 32'd0);
         @(negedge clk);
         chk_out($sformatf("vec%0d", i), vt[i].res);
         chk($sformatf("vec%0d_ones", i), 32'(ones), 32'(vt[i].ones));
      end
      // streaming XOR then AND
      @(negedge clk);
      drive(1'b1, 3'd2, 16'h0475, 16'h5976, 1'b0, 1'b0, 1'b0);
      #1 chk("strm_rdy0", 32'(in_ready), 32'd1);
      @(negedge clk);
      drive(1'b1, 3'd0, 16'h0475, 16'h5976, 1'b0, 1'b0, 1'b0);
      #1 chk("strm_rdy1", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk_out("strm_xor", 16'h5D03);
      @(negedge clk);
      chk_out("strm_and", 16'h0074);
      // accumulate back-to-back, then clear racing a write
      @(negedge clk);
      drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      drive(1'b1, 3'd1, 16'hFFFF, 16'h00F0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b1, 3'd1, 16'hFFFF, 16'h0F00, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b1, 3'd1, 16'h0000, 16'h1111, 1'b1, 1'b1, 1'b1);
      chk_out("acc_1", 16'h00F0);
      @(negedge clk);
      drive(1'b1, 3'd1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
      chk_out("acc_2", 16'h0FF0);
      @(negedge clk);
      in_valid = 1'b0;
      chk_out("acc_preclr", 16'h1FF1);
      @(negedge clk);
      chk_out("acc_cleared", 16'h0000);
      // backpressure: two accepted, third refused until release
      @(negedge clk);
      out_ready = 1'b0;
      drive(1'b1, 3'd7, 16'h0, 16'h0001, 1'b0, 1'b0, 1'b0);
      #1 chk("bp_rdy1", 32'(in_ready), 32'd1);
      @(negedge clk);
      drive(1'b1, 3'd7, 16'h0, 16'h0002, 1'b0, 1'b0, 1'b0);
      #1 chk("bp_rdy2", 32'(in_ready), 32'd1);
      @(negedge clk);
      drive(1'b1, 3'd7, 16'h0, 16'h0003, 1'b0, 1'b0, 1'b0);
      #1 chk("bp_rdy3", 32'(in_ready), 32'd0);
      chk_out("bp_hold0", 16'h0001);
      repeat (2) begin
         @(negedge clk);
         chk("bp_rdy_held", 32'(in_ready), 32'd0);
         chk_out("bp_hold", 16'h0001);
      end
      out_ready = 1'b1;
      #1 chk("bp_rdy_rel", 32'(in_ready), 32'd1);
      chk_out("bp_out1", 16'h0001);
      @(negedge clk);
      in_valid = 1'b0;
      chk_out("bp_out2", 16'h0002);
      @(negedge clk);
      chk_out("bp_out3", 16'h0003);
      @(negedge clk);
      chk("bp_empty", 32'(out_valid), 32'd0);
      // reset mid-flight
      out_ready = 1'b0;
      drive(1'b1, 3'd7, 16'h0, 16'h5555, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b1, 3'd7, 16'h0, 16'h6666, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_res", 32'(result), 32'd0);
      chk("mid_rst_rdy", 32'(in_ready), 32'd1);
      #1 rst_n = 1'b1;
      @(negedge clk);
      out_ready = 1'b1;
      drive(1'b1, 3'd1, 16'hFFFF, 16'h00AA, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("post_rst_lat", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk_out("post_rst", 16'h00AA);
      // randomized traffic against a queue scoreboard
      acc_m = 16'h0;
      prev_stall = 1'b0;
      prev_res = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         drive(1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
               1'($urandom), $urandom_range(7) == 0);
         out_ready = $urandom_range(3) != 0;
         #1;
         if (prev_stall) begin
            chk("rnd_hold_valid", 32'(out_valid), 32'd1);
            chk("rnd_hold_res", 32'(result), 32'(prev_res));
         end
         fire = in_valid && in_ready;
         ofire = out_valid && out_ready;
         if (ofire) begin
            if (q.size() == 0) chk("rnd_spurious", 32'd1, 32'd0);
            else chk_out("rnd", q.pop_front());
         end
         ea = use_acc ? acc_m : a;
         exp_r = ref_op(op, ea, b);
         if (fire) q.push_back(exp_r);
         if (acc_clr) acc_m = '0;
         else if (fire && acc_wr) acc_m = exp_r;
         prev_stall = out_valid && !out_ready;
         prev_res = result;
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (out_valid) begin
            if (q.size() == 0) chk("drain_spurious", 32'd1, 32'd0);
            else chk_out("drain", q.pop_front());
         end
         @(negedge clk);
      end
      chk("drain_left", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
